csr_ctrl: RTL and testbench

Sequencing controller that drives the 4-entry, 64-bit CSR register file from the execute stage. Accepts one CSR instruction at a time (CSRRW/CSRRS/CSRRC, ECALL, MRET) over a valid/ready request, performs the read-modify-write or trap-entry/return sequence over the file's single read and single write port, and returns the old CSR value plus an optional PC redirect over a valid/ready response.

---
 rtl/csr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_csr_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl.sv
// Sequencer for CSRRW/S/C, ECALL and MRET over a 4-entry CSR file with one read and one write port.
// Optional CSR_CTRL_ILLEGAL_TRAP_EN: illegal requests trap to mtvec with mcause=2 instead of completing as no-ops.
module csr_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [11:0]           req_csr,
    input  logic [DATA_WIDTH-1:0] req_src,
    input  logic [DATA_WIDTH-1:0] req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_redirect,
    output logic [DATA_WIDTH-1:0] rsp_target,
    output logic                  rsp_illegal,
    output logic [ADDR_WIDTH-1:0] csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [ADDR_WIDTH-1:0] csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_wen
);

`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_ILLEGAL = 1'b1;
`else
    localparam bit TRAP_ILLEGAL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, EXEC, CAUSE, VEC, MSTAT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              op_q;
    logic [11:0]             csr_q;
    logic [DATA_WIDTH-1:0]   src_q, pc_q;
    logic [DATA_WIDTH-1:0]   rdata_nxt, target_nxt;
    logic                    redirect_nxt, illegal_nxt, wen_c;
    logic [ADDR_WIDTH-1:0]   csr_idx;
    logic                    csr_ok, is_rwx, is_illegal;

    always_comb begin
        csr_ok  = 1'b1;
        csr_idx = '0;
        case (csr_q)
            12'h305: csr_idx = ADDR_WIDTH'(0);
            12'h341: csr_idx = ADDR_WIDTH'(1);
            12'h342: csr_idx = ADDR_WIDTH'(2);
            12'h300: csr_idx = ADDR_WIDTH'(3);
            default: csr_ok  = 1'b0;
        endcase
        is_rwx     = (op_q <= 3'd2);
        is_illegal = (op_q > 3'd4) || (is_rwx && !csr_ok);
    end

    always_comb begin
        state_nxt    = state;
        csr_raddr    = '0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        wen_c        = 1'b0;
        rdata_nxt    = rsp_rdata;
        target_nxt   = rsp_target;
        redirect_nxt = rsp_redirect;
        illegal_nxt  = rsp_illegal;
        case (state)
            IDLE: if (req_valid) state_nxt = EXEC;
            EXEC: begin
                rdata_nxt   = '0;
                illegal_nxt = is_illegal;
                if (op_q == 3'd3 || (is_illegal && TRAP_ILLEGAL)) begin
                    csr_waddr = ADDR_WIDTH'(1);
                    csr_wdata = pc_q;
                    wen_c     = 1'b1;
                    state_nxt = CAUSE;
                end else if (is_illegal) begin
                    state_nxt = RESP;
                end else if (op_q == 3'd4) begin
                    csr_raddr    = ADDR_WIDTH'(1);
                    target_nxt   = csr_rdata;
                    redirect_nxt = 1'b1;
                    state_nxt    = MSTAT;
                end else begin
                    csr_raddr = csr_idx;
                    csr_waddr = csr_idx;
                    rdata_nxt = csr_rdata;
                    case (op_q)
                        3'd0:    csr_wdata = src_q;
                        3'd1:    csr_wdata = csr_rdata | src_q;
                        default: csr_wdata = csr_rdata & ~src_q;
                    endcase
                    // Set/clear with a zero mask must leave the file untouched
                    wen_c     = (op_q == 3'd0) || (src_q != '0);
                    state_nxt = RESP;
                end
            end
            CAUSE: begin
                csr_waddr = ADDR_WIDTH'(2);
                csr_wdata = rsp_illegal ? DATA_WIDTH'(2) : DATA_WIDTH'(11);
                wen_c     = 1'b1;
                state_nxt = VEC;
            end
            VEC: begin
                csr_raddr    = ADDR_WIDTH'(0);
                target_nxt   = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                redirect_nxt = 1'b1;
                state_nxt    = RESP;
            end
            MSTAT: begin
                csr_raddr    = ADDR_WIDTH'(3);
                csr_waddr    = ADDR_WIDTH'(3);
                csr_wdata    = csr_rdata;
                csr_wdata[3] = csr_rdata[7];
                csr_wdata[7] = 1'b1;
                wen_c        = 1'b1;
                state_nxt    = RESP;
            end
            RESP: if (rsp_ready) begin
                redirect_nxt = 1'b0;
                illegal_nxt  = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign csr_wen   = wen_c && !rst;
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            csr_q        <= '0;
            src_q        <= '0;
            pc_q         <= '0;
            rsp_rdata    <= '0;
            rsp_target   <= '0;
            rsp_redirect <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else begin
            state        <= state_nxt;
            rsp_rdata    <= rdata_nxt;
            rsp_target   <= target_nxt;
            rsp_redirect <= redirect_nxt;
            rsp_illegal  <= illegal_nxt;
            if (state == IDLE && req_valid) begin
                op_q  <= req_op;
                csr_q <= req_csr;
                src_q <= req_src;
                pc_q  <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: owns the CSR file and predicts each transaction's response and file contents.
module tb_csr_ctrl;

`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_csr = '0;
    logic [63:0] req_src = '0, req_pc = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [63:0] rsp_rdata, rsp_target;
    logic        rsp_redirect, rsp_illegal;
    logic [1:0]  csr_raddr, csr_waddr;
    logic [63:0] csr_rdata, csr_wdata;
    logic        csr_wen;

    csr_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr(req_csr), .req_src(req_src), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_wen(csr_wen)
    );

    always #5 clk = ~clk;

    // The register file lives here; ld_* lets the bench preload it
    logic [63:0] rf [4];
    logic        ld_en = 1'b0;
    logic [1:0]  ld_idx = '0;
    logic [63:0] ld_val = '0;
    int          n_wr = 0;
    assign csr_rdata = rf[csr_raddr];
    always @(posedge clk) begin
        if (csr_wen) begin
            rf[csr_waddr] <= csr_wdata;
            n_wr <= n_wr + 1;
        end else if (ld_en) begin
            rf[ld_idx] <= ld_val;
        end
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model state
    logic [63:0] exp_file [4];
    logic [63:0] exp_rdata, exp_target;
    logic        exp_redirect, exp_illegal;
    int          exp_lat, exp_wr;
    logic        pend = 1'b0, chk_en = 1'b0;
    logic [63:0] last_rdata, last_target;
    logic        last_redirect, last_illegal;
    int          last_wr;

    function automatic int csr_index(input logic [11:0] a);
        case (a)
            12'h305: return 0;
            12'h341: return 1;
            12'h342: return 2;
            12'h300: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [63:0] src, input logic [63:0] pc);
        int idx;
        logic illegal;
        logic [63:0] old, st;
        idx = csr_index(a);
        illegal = (op > 3'd4) || (op <= 3'd2 && idx < 0);
        exp_rdata = '0; exp_redirect = 1'b0; exp_illegal = illegal; exp_wr = 0; exp_lat = 2;
        if (op <= 3'd2 && !illegal) begin
            old = exp_file[idx];
            exp_rdata = old;
            if (op == 3'd0 || src != 0) begin
                exp_file[idx] = (op == 3'd0) ? src : (op == 3'd1) ? (old | src) : (old & ~src);
                exp_wr = 1;
            end
        end else if (op == 3'd3 || (illegal && TRAP)) begin
            exp_file[1] = pc;
            exp_file[2] = illegal ? 64'd2 : 64'd11;
            exp_target = exp_file[0] & ~64'd3;
            exp_redirect = 1'b1; exp_wr = 2; exp_lat = 4;
        end else if (op == 3'd4) begin
            exp_target = exp_file[1];
            st = exp_file[3];
            st[3] = st[7];
            st[7] = 1'b1;
            exp_file[3] = st;
            exp_redirect = 1'b1; exp_wr = 1; exp_lat = 3;
        end
    endtask

    // Per-cycle compare against the model's view of the outstanding transaction
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, !pend});
            if (!pend) begin
                chk("rsp_valid_idle", {63'd0, rsp_valid}, 64'd0);
            end else if (rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, exp_illegal});
                chk("rsp_redirect", {63'd0, rsp_redirect}, {63'd0, exp_redirect});
                if (exp_redirect) chk("rsp_target", rsp_target, exp_target);
                chk("wen_in_resp", {63'd0, csr_wen}, 64'd0);
            end
        end
    end

    task automatic set_csr(input int idx, input logic [63:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 2'(idx); ld_val = v;
        exp_file[idx] = v;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [11:0] a, input logic [63:0] src,
                           input logic [63:0] pc, input int stall);
        int edges, held, w0;
        logic hs;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_csr = a; req_src = src; req_pc = pc;
        model(op, a, src, pc);
        w0 = n_wr;
        @(posedge clk);
        pend = 1'b1;
        #1 req_valid = 1'b0;
        edges = 0; held = 0; hs = 1'b0;
        for (int k = 0; k < 60 && !hs; k++) begin
            @(negedge clk);
            if (rsp_valid && held < stall) begin
                rsp_ready = 1'b0;
                held++;
            end else begin
                rsp_ready = 1'b1;
            end
            hs = rsp_valid && rsp_ready;
            if (hs) begin
                last_rdata = rsp_rdata; last_target = rsp_target;
                last_redirect = rsp_redirect; last_illegal = rsp_illegal;
            end
            @(posedge clk);
            edges++;
        end
        #1;
        pend = 1'b0;
        chk("handshake_seen", {63'd0, hs}, 64'd1);
        chk("latency", 64'(edges), 64'(exp_lat + stall));
        last_wr = n_wr - w0;
        chk("write_count", 64'(last_wr), 64'(exp_wr));
        for (int i = 0; i < 4; i++) chk("file", rf[i], exp_file[i]);
    endtask

    initial begin
        int w0;
        logic [2:0]  op;
        logic [11:0] a;
        logic [63:0] src;
        for (int i = 0; i < 4; i++) begin rf[i] = '0; exp_file[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_redirect", {63'd0, rsp_redirect}, 64'd0);
        chk("rst_illegal", {63'd0, rsp_illegal}, 64'd0);
        chk("rst_wen", {63'd0, csr_wen}, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_target", rsp_target, 64'd0);
        chk("rst_waddr", {62'd0, csr_waddr}, 64'd0);
        chk("rst_wdata", csr_wdata, 64'd0);
        chk("rst_raddr", {62'd0, csr_raddr}, 64'd0);
        chk_en = 1'b1;

        set_csr(1, 64'h1234);
        run_txn(3'd0, 12'h341, 64'h8000_0010, 64'h0, 0);
        chk("csrrw_rdata_lit", last_rdata, 64'h1234);
        chk("csrrw_mepc_lit", rf[1], 64'h8000_0010);

        set_csr(3, 64'h80);
        run_txn(3'd1, 12'h300, 64'h8, 64'h0, 0);
        chk("csrrs_rdata_lit", last_rdata, 64'h80);
        run_txn(3'd2, 12'h300, 64'h80, 64'h0, 0);
        chk("csrrc_rdata_lit", last_rdata, 64'h88);
        chk("mstatus_lit", rf[3], 64'h8);
        run_txn(3'd1, 12'h300, 64'h0, 64'h0, 0);
        chk("csrrs0_nowrite_lit", 64'(last_wr), 64'd0);

        set_csr(0, 64'h8000_0003);
        run_txn(3'd3, 12'h000, 64'h0, 64'h8000_0100, 0);
        chk("ecall_target_lit", last_target, 64'h8000_0000);
        chk("ecall_redirect_lit", {63'd0, last_redirect}, 64'd1);
        chk("ecall_mepc_lit", rf[1], 64'h8000_0100);
        chk("ecall_mcause_lit", rf[2], 64'd11);

        set_csr(1, 64'h8000_0104);
        set_csr(3, 64'h80);
        run_txn(3'd4, 12'h000, 64'h0, 64'h0, 5);
        chk("mret_target_lit", last_target, 64'h8000_0104);
        chk("mret_mstatus_lit", rf[3], 64'h88);

        set_csr(2, 64'h55);
        run_txn(3'd0, 12'h7C0, 64'hDEAD_BEEF, 64'h8000_0200, 0);
        chk("illegal_flag_lit", {63'd0, last_illegal}, 64'd1);
        chk("illegal_rdata_lit", last_rdata, 64'd0);
`ifdef CSR_CTRL_ILLEGAL_TRAP_EN
        chk("illegal_mcause_lit", rf[2], 64'd2);
        chk("illegal_redirect_lit", {63'd0, last_redirect}, 64'd1);
`else
        chk("illegal_mcause_lit", rf[2], 64'h55);
        chk("illegal_redirect_lit", {63'd0, last_redirect}, 64'd0);
`endif

        // Reset during the CAUSE step of an ECALL: mepc written, mcause untouched
        chk_en = 1'b0;
        set_csr(2, 64'h77);
        w0 = n_wr;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 64'h8000_0300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_abort_wen", {63'd0, csr_wen}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_abort_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_abort_mepc", rf[1], 64'h8000_0300);
        chk("rst_abort_mcause", rf[2], 64'h77);
        chk("rst_abort_writes", 64'(n_wr - w0), 64'd1);
        exp_file[1] = 64'h8000_0300;
        chk_en = 1'b1;

        for (int t = 0; t < 150; t++) begin
            op = 3'($urandom_range(0, 9) > 8 ? $urandom_range(5, 7) : $urandom_range(0, 4));
            case ($urandom_range(0, 4))
                0: a = 12'h305;
                1: a = 12'h341;
                2: a = 12'h342;
                3: a = 12'h300;
                default: a = 12'($urandom);
            endcase
            src = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            run_txn(op, a, src, {32'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
